// File: rtl/pk_decode_ctrl.sv
// rtl/pk_decode_ctrl.sv - ML-DSA pk decoder: rho capture plus one shared 10-bit t1 bit-unpacker
// Optional framing check: PK_DECODE_CTRL_LEN_CHECK_EN
module pk_decode_ctrl #(
  parameter int K = 8,
  parameter int D = 13,
  parameter int Q = 8380417,
  localparam int COEF_W = $clog2(Q) - D,
  localparam int POLY_BYTES = 32 * COEF_W,
  localparam int PK_BYTES = 32 + K * POLY_BYTES,
  localparam int PW = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [255:0]      rho,
  output logic              rho_valid,
  output logic [COEF_W-1:0] coef,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [PW-1:0]     coef_poly,
  output logic [7:0]        coef_idx,
  output logic              coef_last,
  output logic              err
);

  localparam int ACC_W = COEF_W + 7;
  localparam int AC_W  = $clog2(ACC_W + 1);
  localparam int CNT_W = $clog2(PK_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RHO, S_T1, S_DONE} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [AC_W-1:0]    acc_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic               byte_acc, coef_hs;

  assign byte_acc = in_valid && in_ready;
  assign coef_hs  = coef_valid && coef_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RHO;
      S_RHO:  if (byte_acc && byte_cnt == CNT_W'(31)) state_next = S_T1;
      S_T1:   if (coef_hs && coef_last) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs depend only on registered state, so they are glitch-free.
  always_comb begin
    busy       = (state == S_RHO) || (state == S_T1);
    done       = (state == S_DONE);
    in_ready   = (state == S_RHO) || ((state == S_T1) && (acc_cnt < AC_W'(COEF_W)));
    coef_valid = (state == S_T1) && (acc_cnt >= AC_W'(COEF_W));
    coef       = acc[COEF_W-1:0];
    coef_last  = coef_valid && (coef_poly == PW'(K - 1)) && (coef_idx == 8'd255);
  end

  // Accept and emit are exclusive: in_ready and coef_valid split on acc_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rho       <= '0;
      rho_valid <= 1'b0;
      acc       <= '0;
      acc_cnt   <= '0;
      byte_cnt  <= '0;
      coef_poly <= '0;
      coef_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rho       <= '0;
            rho_valid <= 1'b0;
            acc       <= '0;
            acc_cnt   <= '0;
            byte_cnt  <= '0;
            coef_poly <= '0;
            coef_idx  <= '0;
          end
        end
        S_RHO: begin
          if (byte_acc) begin
            rho[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == CNT_W'(31)) rho_valid <= 1'b1;
          end
        end
        S_T1: begin
          if (byte_acc) begin
            acc      <= acc | (ACC_W'(in_data) << acc_cnt);
            acc_cnt  <= acc_cnt + AC_W'(8);
            byte_cnt <= byte_cnt + CNT_W'(1);
          end else if (coef_hs) begin
            acc      <= acc >> COEF_W;
            acc_cnt  <= acc_cnt - AC_W'(COEF_W);
            coef_idx <= coef_idx + 8'd1;
            if (coef_idx == 8'd255)
              coef_poly <= (coef_poly == PW'(K - 1)) ? '0 : coef_poly + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PK_DECODE_CTRL_LEN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= byte_acc && (in_last != (byte_cnt == CNT_W'(PK_BYTES - 1)));
  end
  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pk_decode_ctrl.sv
// tb/tb_pk_decode_ctrl.sv - scoreboard bench for pk_decode_ctrl
module tb_pk_decode_ctrl;
  localparam int K = 8;
  localparam int PK_BYTES = 2592;
  localparam int NCOEF = K * 256;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, in_last, coef_ready;
  logic [7:0]   in_data;
  logic         busy, done, in_ready, rho_valid, coef_valid, coef_last, err;
  logic [255:0] rho;
  logic [9:0]   coef;
  logic [2:0]   coef_poly;
  logic [7:0]   coef_idx;

  always #5 clk = ~clk;

  pk_decode_ctrl #(.K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .rho(rho), .rho_valid(rho_valid), .coef(coef), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .coef_poly(coef_poly), .coef_idx(coef_idx),
    .coef_last(coef_last), .err(err)
  );

  typedef struct {
    logic [9:0] c;
    logic [2:0] p;
    logic [7:0] i;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pk[PK_BYTES];
  logic [9:0] got[NCOEF];
  int         errors = 0;
  int         checks = 0;

  // Golden SimpleBitUnpack: coefficient n occupies bits [10n+9:10n] after the 256-bit rho.
  task automatic build_model();
    exp_q.delete();
    for (int n = 0; n < NCOEF; n++) begin
      exp_t e;
      e.c = '0;
      for (int b = 0; b < 10; b++) begin
        int pos;
        pos = 256 + n * 10 + b;
        e.c[b] = pk[pos / 8][pos % 8];
      end
      e.p = 3'(n / 256);
      e.i = 8'(n % 256);
      e.l = (n == NCOEF - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_pk(input int t1_mode);
    for (int i = 0; i < PK_BYTES; i++)
      pk[i] = (i < 32) ? 8'(i) : (t1_mode == 0) ? 8'hFF : 8'($urandom_range(0, 255));
  endtask

  task automatic run_decode(input int stall_from, input int stall_len, input int start_at,
                            input int rst_at, input int last_at,
                            output int done_cyc, output int last_hs_cyc);
    int cyc, bidx, n;
    logic hold, pend, err_exp, hl;
    logic [9:0] hc;
    logic [2:0] hp;
    logic [7:0] hi;
    logic [255:0] exp_rho;
    exp_t e;
    build_model();
    done_cyc = -1; last_hs_cyc = -1;
    hold = 1'b0; pend = 1'b0; err_exp = 1'b0;
    hc = '0; hp = '0; hi = '0; hl = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    cyc = 1; bidx = 0; n = 0;
    while (cyc < 6000) begin
      in_valid   = (bidx < PK_BYTES);
      in_data    = in_valid ? pk[bidx] : 8'h00;
      in_last    = (bidx == last_at);
      coef_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      start      = (cyc == start_at);
      #1;
      if (pend) begin
        checks++;
        if (err !== err_exp) begin
          errors++;
          $display("FAIL err byte=%0d got %b want %b", bidx - 1, err, err_exp);
        end
      end
      pend = 1'b0;
      if (hold) begin
        checks++;
        if ({coef_valid, coef, coef_poly, coef_idx, coef_last} !== {1'b1, hc, hp, hi, hl}) begin
          errors++;
          $display("FAIL hold cyc=%0d got v=%b %h/%0d/%0d want %h/%0d/%0d",
                   cyc, coef_valid, coef, coef_poly, coef_idx, hc, hp, hi);
        end
      end
      if (start_at > 0 && cyc == start_at + 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_start got %b want 1", busy);
        end
      end
      if (stall_len > 0 && cyc == stall_from + stall_len - 1) begin
        checks++;
        if ({in_ready, coef_valid} !== 2'b01) begin
          errors++;
          $display("FAIL stall in_ready/coef_valid got %b%b want 01", in_ready, coef_valid);
        end
      end
      if (coef_valid && coef_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_coef got %h want none", coef);
        end else begin
          e = exp_q.pop_front();
          if ({coef, coef_poly, coef_idx, coef_last} !== {e.c, e.p, e.i, e.l}) begin
            errors++;
            $display("FAIL coef n=%0d got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     n, coef, coef_poly, coef_idx, coef_last, e.c, e.p, e.i, e.l);
          end
        end
        if (n < NCOEF) got[n] = coef;
        n++;
        if (coef_last) last_hs_cyc = cyc;
      end
      hold = coef_valid && !coef_ready;
      hc = coef; hp = coef_poly; hi = coef_idx; hl = coef_last;
      if (in_valid && in_ready) begin
        pend = 1'b1;
`ifdef PK_DECODE_CTRL_LEN_CHECK_EN
        err_exp = (in_last != (bidx == PK_BYTES - 1));
`else
        err_exp = 1'b0;
`endif
        bidx++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rst_at >= 0 && bidx == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, rho_valid, coef_valid} !== 3'b000) begin
          errors++;
          $display("FAIL rst_mid busy/rho_valid/coef_valid got %b%b%b want 000",
                   busy, rho_valid, coef_valid);
        end
        @(negedge clk); rst = 1'b0;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0; coef_ready = 1'b1;
    if (rst_at < 0) begin
      checks++;
      if (done_cyc < 0 || n != NCOEF || exp_q.size() != 0) begin
        errors++;
        $display("FAIL completion done_cyc=%0d coefs=%0d left=%0d want done, %0d coefs, 0 left",
                 done_cyc, n, exp_q.size(), NCOEF);
      end
      for (int i = 0; i < 32; i++) exp_rho[8*i +: 8] = pk[i];
      @(posedge clk); @(negedge clk);
      checks++;
      if ({busy, done, rho_valid, rho} !== {1'b0, 1'b0, 1'b1, exp_rho}) begin
        errors++;
        $display("FAIL after_done busy=%b done=%b rho_valid=%b rho=%h want 0 0 1 %h",
                 busy, done, rho_valid, rho, exp_rho);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; coef_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, in_ready, rho_valid, coef_valid, coef_last, err} !== 7'b0 ||
        rho !== '0 || coef !== '0 || coef_poly !== '0 || coef_idx !== '0) begin
      errors++;
      $display("FAIL reset flags=%b rho=%h coef=%h poly=%0d idx=%0d want all zero",
               {busy, done, in_ready, rho_valid, coef_valid, coef_last, err},
               rho, coef, coef_poly, coef_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_throughput();
    int dc, lc;
    fill_pk(0);
    run_decode(-100, 0, -1, -1, PK_BYTES - 1, dc, lc);
    checks++;
    if (lc != 32 + 576 * K) begin
      errors++;
      $display("FAIL last_hs_cycle got %0d want %0d", lc, 32 + 576 * K);
    end
    checks++;
    if (dc != 33 + 576 * K) begin
      errors++;
      $display("FAIL done_cycle got %0d want %0d", dc, 33 + 576 * K);
    end
  endtask

  task automatic test_pattern();
    int dc, lc;
    int want[6] = '{1, 0, 0, 0, 0, 1};
    fill_pk(1);
    for (int i = 0; i < 10; i++) pk[32 + i] = 8'h00;
    pk[32] = 8'h01;
    pk[38] = 8'h04;
    run_decode(-100, 0, -1, -1, PK_BYTES - 1, dc, lc);
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (got[j] !== 10'(want[j])) begin
        errors++;
        $display("FAIL pattern coef%0d got %0d want %0d", j, got[j], want[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int dc, lc;
    fill_pk(1);
    run_decode(300, 20, -1, -1, PK_BYTES - 1, dc, lc);
  endtask

  task automatic test_reset_mid();
    int dc, lc;
    fill_pk(1);
    run_decode(-100, 0, -1, 500, PK_BYTES - 1, dc, lc);
    repeat (2) @(negedge clk);
    fill_pk(1);
    run_decode(-100, 0, -1, -1, PK_BYTES - 1, dc, lc);
  endtask

  task automatic test_start_ignored();
    int dc, lc;
    fill_pk(1);
    run_decode(-100, 0, 1000, -1, PK_BYTES - 1, dc, lc);
  endtask

  task automatic test_len_check();
    int dc, lc;
    fill_pk(1);
    run_decode(-100, 0, -1, -1, PK_BYTES - 2, dc, lc);
  endtask

  initial begin
    test_reset();
    test_full_throughput();
    test_pattern();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_len_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
